// File: rtl/digital_mod_pkg.sv
// Shared mode encodings, FSM state type and default widths for the multi-mode modulator.
package digital_mod_pkg;

    localparam int DEF_PHASE_W = 32;
    localparam int DEF_LUT_AW  = 10;
    localparam int DEF_OUT_W   = 12;
    localparam int DEF_SYM_LEN = 120;

    typedef enum logic [1:0] {
        MOD_ASK  = 2'b00,
        MOD_FSK  = 2'b01,
        MOD_BPSK = 2'b10,
        MOD_RSVD = 2'b11
    } mod_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mod_sine_lut.sv
// Synchronous-read full-cycle sine ROM; contents are computed at elaboration.
module mod_sine_lut
    import digital_mod_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [OUT_W-1:0] data
);

    localparam int DEPTH = 1 << LUT_AW;

    logic signed [OUT_W-1:0] rom [DEPTH];

    // Peak is 2^(OUT_W-1)-1, so the most negative code never appears and negation cannot overflow.
    function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
        real ang;
        real x;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
        x   = real'((1 << (OUT_W - 1)) - 1) * $sin(ang);
        r   = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        return OUT_W'(r);
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        assign rom[k] = sine_entry(k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/digital_mod_core.sv
// Multi-mode DDS modulator (ASK/FSK/BPSK) with one shared phase accumulator.
// Optional build macro DIGITAL_MOD_BPSK_EN enables the BPSK negation path.
module digital_mod_core
    import digital_mod_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SYM_LEN = DEF_SYM_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [PHASE_W-1:0]       fcw0,
    input  logic [PHASE_W-1:0]       fcw1,
    input  logic                     bit_data,
    input  logic                     bit_valid,
    output logic                     bit_ready,
    output logic signed [OUT_W-1:0] mod_data,
    output logic                     mod_valid,
    output logic                     sym_tick,
    output logic                     underrun,
    output logic                     busy
);

    localparam int CNT_W = $clog2(SYM_LEN);

    state_e                  state;
    state_e                  state_nxt;
    logic [CNT_W-1:0]        sym_cnt;
    logic                    term;
    logic                    accept;
    logic                    underrun_nxt;

    logic [PHASE_W-1:0]      phase_p0;
    logic [PHASE_W-1:0]      inc_p0;
    logic [PHASE_W-1:0]      fcw0_q;
    logic [PHASE_W-1:0]      fcw1_q;
    logic                    bit_p0;
    mod_e                    mode_p0;
    logic                    vld_p0;

    logic signed [OUT_W-1:0] lut_p1;
    logic                    bit_p1;
    mod_e                    mode_p1;
    logic                    vld_p1;
    logic signed [OUT_W-1:0] sample_p1;

`ifdef DIGITAL_MOD_BPSK_EN
    function automatic logic signed [OUT_W-1:0] neg_sat(input logic signed [OUT_W-1:0] x);
        if (x == {1'b1, {(OUT_W - 1){1'b0}}}) begin
            return {1'b0, {(OUT_W - 1){1'b1}}};
        end
        return -x;
    endfunction
`endif

    assign term   = (sym_cnt == CNT_W'(SYM_LEN - 1));
    assign vld_p0 = (state == ST_RUN);
    assign busy   = vld_p0;
    assign inc_p0 = (mode_p0 == MOD_FSK && bit_p0) ? fcw1_q : fcw0_q;

    always_comb begin
        state_nxt    = state;
        bit_ready    = 1'b0;
        accept       = 1'b0;
        underrun_nxt = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: bit_ready = enable;
                ST_RUN:  bit_ready = enable & term;
                default: bit_ready = 1'b0;
            endcase
        end
        accept = bit_valid & bit_ready;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (term && !accept) begin
                    state_nxt    = ST_IDLE;
                    underrun_nxt = enable & ~bit_valid;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage 0: FSM, symbol counter, latched symbol settings and phase accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sym_cnt  <= '0;
            sym_tick <= 1'b0;
            underrun <= 1'b0;
            phase_p0 <= '0;
            bit_p0   <= 1'b0;
            mode_p0  <= MOD_ASK;
            fcw0_q   <= '0;
            fcw1_q   <= '0;
        end else begin
            state    <= state_nxt;
            sym_tick <= accept;
            underrun <= underrun_nxt;
            if (accept) begin
                bit_p0  <= bit_data;
                mode_p0 <= mod_e'(mode);
                fcw0_q  <= fcw0;
                fcw1_q  <= fcw1;
            end
            if (state == ST_RUN && !term) begin
                sym_cnt <= sym_cnt + 1'b1;
            end else begin
                sym_cnt <= '0;
            end
            // Phase keeps running across symbol boundaries and only returns to zero in IDLE.
            if (state == ST_RUN && state_nxt == ST_RUN) begin
                phase_p0 <= phase_p0 + inc_p0;
            end else begin
                phase_p0 <= '0;
            end
        end
    end

    // Stage 1: registered sine lookup with mode/bit/valid carried alongside
    mod_sine_lut #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_lut (
        .clk  (clk),
        .rst  (rst),
        .addr (phase_p0[PHASE_W-1 -: LUT_AW]),
        .data (lut_p1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_p1  <= 1'b0;
            mode_p1 <= MOD_ASK;
            vld_p1  <= 1'b0;
        end else begin
            bit_p1  <= bit_p0;
            mode_p1 <= mode_p0;
            vld_p1  <= vld_p0;
        end
    end

    always_comb begin
        sample_p1 = '0;
        case (mode_p1)
            MOD_ASK: sample_p1 = bit_p1 ? lut_p1 : '0;
            MOD_FSK: sample_p1 = lut_p1;
`ifdef DIGITAL_MOD_BPSK_EN
            MOD_BPSK: sample_p1 = bit_p1 ? lut_p1 : neg_sat(lut_p1);
`endif
            default: sample_p1 = '0;
        endcase
    end

    // Stage 2: output mux register; idle cycles always present zero
    always_ff @(posedge clk) begin
        if (rst) begin
            mod_data  <= '0;
            mod_valid <= 1'b0;
        end else begin
            mod_data  <= vld_p1 ? sample_p1 : '0;
            mod_valid <= vld_p1;
        end
    end

endmodule

// File: tb/tb_digital_mod_core.sv
// Randomized self-checking bench for digital_mod_core against a symbol-level reference model.
module tb_digital_mod_core;

    localparam int PHASE_W = 32;
    localparam int LUT_AW  = 10;
    localparam int OUT_W   = 12;
    localparam int SYM_LEN = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [1:0]               mode;
    logic [PHASE_W-1:0]       fcw0;
    logic [PHASE_W-1:0]       fcw1;
    logic                     bit_data;
    logic                     bit_valid;
    logic                     bit_ready;
    logic signed [OUT_W-1:0]  mod_data;
    logic                     mod_valid;
    logic                     sym_tick;
    logic                     underrun;
    logic                     busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic                     sym_bit  [16];
    logic [1:0]               sym_mode [16];
    logic [PHASE_W-1:0]       sym_f0   [16];
    logic [PHASE_W-1:0]       sym_f1   [16];
    logic signed [OUT_W-1:0]  exp_q [$];
    logic signed [OUT_W-1:0]  cap   [$];

    always #5 clk = ~clk;

    digital_mod_core #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .OUT_W   (OUT_W),
        .SYM_LEN (SYM_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .fcw0      (fcw0),
        .fcw1      (fcw1),
        .bit_data  (bit_data),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .mod_data  (mod_data),
        .mod_valid (mod_valid),
        .sym_tick  (sym_tick),
        .underrun  (underrun),
        .busy      (busy)
    );

    function automatic int sine_ref(input int idx);
        real x;
        x = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(idx) / 1024.0);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    task automatic drive_junk();
        bit_data = 1'($urandom);
        mode     = 2'($urandom);
        fcw0     = $urandom;
        fcw1     = $urandom;
    endtask

    // Runs n back-to-back symbols from sym_* and checks every cycle; edge 0 is the first accept.
    task automatic run_symbols(input int n, input bit drop_en);
        logic [PHASE_W-1:0]      ph;
        int                      s;
        int                      j;
        logic signed [OUT_W-1:0] ev;
        logic                    exp_tick, exp_busy, exp_vld, exp_ur, exp_rdy;
        exp_q.delete();
        cap.delete();
        ph = '0;
        for (int si = 0; si < n; si++) begin
            for (int k = 0; k < SYM_LEN; k++) begin
                s = sine_ref(int'(ph[PHASE_W-1 -: LUT_AW]));
                case (sym_mode[si])
                    2'b00: s = sym_bit[si] ? s : 0;
                    2'b01: s = s;
`ifdef DIGITAL_MOD_BPSK_EN
                    2'b10: s = sym_bit[si] ? s : -s;
`endif
                    default: s = 0;
                endcase
                exp_q.push_back(OUT_W'(s));
                ph = ph + ((sym_mode[si] == 2'b01 && sym_bit[si]) ? sym_f1[si] : sym_f0[si]);
            end
        end
        enable    = 1'b1;
        bit_valid = 1'b1;
        bit_data  = sym_bit[0];
        mode      = sym_mode[0];
        fcw0      = sym_f0[0];
        fcw1      = sym_f1[0];
        for (int e = 0; e < n * SYM_LEN + 4; e++) begin
            @(posedge clk);
            #1;
            exp_tick = (e % SYM_LEN == 0) && (e < n * SYM_LEN);
            exp_busy = (e < n * SYM_LEN);
            exp_vld  = (e >= 2) && (e < n * SYM_LEN + 2);
            exp_ur   = (e == n * SYM_LEN) && !drop_en;
            ev = '0;
            if (exp_vld) ev = exp_q[e - 2];
            n_checks++;
            if (mod_data !== ev) $display("FAIL mod_data e=%0d got %0d want %0d", e, mod_data, ev);
            else n_pass++;
            n_checks++;
            if (mod_valid !== exp_vld) $display("FAIL mod_valid e=%0d got %b want %b", e, mod_valid, exp_vld);
            else n_pass++;
            n_checks++;
            if (sym_tick !== exp_tick) $display("FAIL sym_tick e=%0d got %b want %b", e, sym_tick, exp_tick);
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy) $display("FAIL busy e=%0d got %b want %b", e, busy, exp_busy);
            else n_pass++;
            n_checks++;
            if (underrun !== exp_ur) $display("FAIL underrun e=%0d got %b want %b", e, underrun, exp_ur);
            else n_pass++;
            cap.push_back(mod_data);
            if (drop_en && e == (n - 1) * SYM_LEN + 3) enable = 1'b0;
            j = (e + 1) / SYM_LEN;
            if (e + 1 >= n * SYM_LEN) begin
                bit_valid = drop_en;
                drive_junk();
            end else if ((e + 1) % SYM_LEN == 0) begin
                bit_valid = 1'b1;
                bit_data  = sym_bit[j];
                mode      = sym_mode[j];
                fcw0      = sym_f0[j];
                fcw1      = sym_f1[j];
            end else begin
                bit_valid = 1'b1;
                drive_junk();
            end
            exp_rdy = enable && ((e + 1 >= n * SYM_LEN) || ((e + 1) % SYM_LEN == 0));
            #1;
            n_checks++;
            if (bit_ready !== exp_rdy) $display("FAIL bit_ready e=%0d got %b want %b", e, bit_ready, exp_rdy);
            else n_pass++;
        end
        enable    = 1'b1;
        bit_valid = 1'b0;
    endtask

    task automatic set_sym(input int i, input logic b, input logic [1:0] m,
                           input logic [PHASE_W-1:0] f0, input logic [PHASE_W-1:0] f1);
        sym_bit[i]  = b;
        sym_mode[i] = m;
        sym_f0[i]   = f0;
        sym_f1[i]   = f1;
    endtask

    task automatic check_all_zero(input string tag);
        n_checks++;
        if ({bit_ready, mod_valid, sym_tick, underrun, busy} !== 5'b0 || mod_data !== '0)
            $display("FAIL %s got rdy=%b vld=%b tick=%b ur=%b busy=%b data=%0d want all 0",
                     tag, bit_ready, mod_valid, sym_tick, underrun, busy, mod_data);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; bit_valid = 1'b0; bit_data = 1'b0;
        mode = 2'b00; fcw0 = '0; fcw1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b0;
        #1;
        n_checks++;
        if (bit_ready !== 1'b1) $display("FAIL idle_ready got %b want 1", bit_ready);
        else n_pass++;
        bit_valid = 1'b1; mode = 2'b01; fcw0 = 32'h4000_0000; fcw1 = 32'h2000_0000;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
            if (e == 3) begin
                n_checks++;
                if (mod_valid !== 1'b1 || mod_data !== 12'sd2047)
                    $display("FAIL pre_reset_run got vld=%b data=%0d want 1/2047", mod_valid, mod_data);
                else n_pass++;
            end
        end
        rst = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            check_all_zero("reset_mid_symbol");
        end
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (mod_valid !== 1'b0 || mod_data !== '0 || busy !== 1'b0)
                $display("FAIL no_drain got vld=%b data=%0d busy=%b want 0/0/0", mod_valid, mod_data, busy);
            else n_pass++;
        end
    endtask

    task automatic test_fsk();
        set_sym(0, 1'b0, 2'b01, 32'h4000_0000, 32'h2000_0000);
        set_sym(1, 1'b1, 2'b01, 32'h4000_0000, 32'h2000_0000);
        run_symbols(2, 1'b0);
        n_checks++;
        if (cap[3] !== 12'sd2047 || cap[5] !== -12'sd2047)
            $display("FAIL fsk_tone0 got %0d,%0d want 2047,-2047", cap[3], cap[5]);
        else n_pass++;
        n_checks++;
        if (cap[10] !== 12'sd0 || cap[11] !== 12'sd1447 || cap[12] !== 12'sd2047)
            $display("FAIL fsk_tone1 got %0d,%0d,%0d want 0,1447,2047", cap[10], cap[11], cap[12]);
        else n_pass++;
    endtask

    task automatic test_ask();
        set_sym(0, 1'b1, 2'b00, 32'h4000_0000, '0);
        set_sym(1, 1'b0, 2'b00, 32'h4000_0000, '0);
        set_sym(2, 1'b1, 2'b00, 32'h4000_0000, '0);
        run_symbols(3, 1'b0);
        for (int k = 0; k < SYM_LEN; k++) begin
            n_checks++;
            if (cap[2 + SYM_LEN + k] !== '0) $display("FAIL ask_off k=%0d got %0d want 0", k, cap[2 + SYM_LEN + k]);
            else n_pass++;
        end
        n_checks++;
        if (cap[3] !== 12'sd2047 || cap[2 + 2 * SYM_LEN + 1] !== 12'sd2047)
            $display("FAIL ask_on got %0d,%0d want 2047,2047", cap[3], cap[2 + 2 * SYM_LEN + 1]);
        else n_pass++;
    endtask

    task automatic test_bpsk();
        logic signed [OUT_W-1:0] w0, w1;
        set_sym(0, 1'b1, 2'b10, 32'h4000_0000, '0);
        set_sym(1, 1'b0, 2'b10, 32'h4000_0000, '0);
        run_symbols(2, 1'b0);
`ifdef DIGITAL_MOD_BPSK_EN
        w0 = 12'sd2047; w1 = -12'sd2047;
`else
        w0 = 12'sd0; w1 = 12'sd0;
`endif
        n_checks++;
        if (cap[3] !== w0 || cap[2 + SYM_LEN + 1] !== w1)
            $display("FAIL bpsk got %0d,%0d want %0d,%0d", cap[3], cap[2 + SYM_LEN + 1], w0, w1);
        else n_pass++;
    endtask

    task automatic test_underrun();
        set_sym(0, 1'($urandom), 2'b01, $urandom, $urandom);
        set_sym(1, 1'($urandom), 2'b00, $urandom, $urandom);
        run_symbols(2, 1'b0);
    endtask

    task automatic test_enable_drop();
        set_sym(0, 1'b1, 2'b01, 32'h1000_0000, 32'h3000_0000);
        set_sym(1, 1'b1, 2'b00, 32'h0800_0000, 32'h0);
        run_symbols(2, 1'b1);
    endtask

    // Junk values on mode/fcw/bit between accepts exercise mid-symbol changes.
    task automatic test_mid_change();
        set_sym(0, 1'b1, 2'b01, 32'h4000_0000, 32'h2000_0000);
        set_sym(1, 1'b1, 2'b00, 32'h1000_0000, 32'h2000_0000);
        run_symbols(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(3, 6);
            for (int i = 0; i < n; i++) set_sym(i, 1'($urandom), 2'($urandom), $urandom, $urandom);
            run_symbols(n, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fsk();
        test_ask();
        test_bpsk();
        test_underrun();
        test_enable_drop();
        test_mid_change();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
